switch_input: RTL and testbench

- Memory-mapped input peripheral for the P8 board: the read-side counterpart of the LED output block.
- Samples the active-low board switch bank, synchronises and debounces it, and presents an active-high 32-bit value to the CPU.
- Latches which bits changed and raises an interrupt request to the CP0 hardware-interrupt line when any debounced bit changes.
- Sits on the system bridge beside the LED, timer and UART devices.

---
 rtl/switch_input.sv | 92 +++++++++
 tb/tb_switch_input.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_input.sv
// Memory-mapped switch bank reader: synchronises and debounces active-low switches,
// latches changed bits and raises a level interrupt to CP0 on any debounced change.
module switch_input #(
  parameter int unsigned WIDTH           = 32,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      data_in,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [31:0]      data_return_cpu,
  output logic             irq
);

  localparam int unsigned CNT_W = 20;
  localparam logic [CNT_W-1:0] CNT_MAX = DEBOUNCE_CYCLES - 20'd1;

  logic [WIDTH-1:0] sync1, sync2, cand, stable, changed, diff;
  logic [CNT_W-1:0] cnt;
  logic             pending, ie;
  logic             settled, change, ctrl_wr, clear;
  logic             unused_data;

  assign unused_data = ^data_in[31:2];

  // Stable-update and bus-write decode
  always_comb begin
    settled = (sync2 == cand) && (cnt == CNT_MAX);
    diff    = cand ^ stable;
    change  = settled && (|diff);
    ctrl_wr = enable && we && (addr == 2'd1);
    clear   = ctrl_wr && data_in[1];
  end

  // Two-flop synchroniser and whole-vector debounce; any bounce restarts the window
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '1;
      sync2  <= '1;
      cand   <= '1;
      stable <= '1;
      cnt    <= '0;
    end else begin
      sync1 <= switch_raw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= cand;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

  // Change latch; a new event in the same cycle as a W1C wins over the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      changed <= '0;
      pending <= 1'b0;
      ie      <= 1'b0;
    end else begin
      if (change) begin
        pending <= 1'b1;
        changed <= clear ? diff : (changed | diff);
      end else if (clear) begin
        pending <= 1'b0;
        changed <= '0;
      end
      if (ctrl_wr) begin
        ie <= data_in[0];
      end
    end
  end

  always_comb begin
    data_return_cpu = '0;
    case (addr)
      2'd0:    data_return_cpu = 32'(~stable);
      2'd1:    data_return_cpu = {30'b0, pending, ie};
      2'd2:    data_return_cpu = 32'(changed);
      default: data_return_cpu = '0;
    endcase
  end

  assign irq = pending & ie;

endmodule

// File: tb/tb_switch_input.sv
// Bench for switch_input: directed literal checks plus randomized traffic against
// a run-length behavioural model of the debounce and interrupt rules.
module tb_switch_input;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] data_in = '0;
  logic [31:0] switch_raw = '1;
  logic [31:0] data_return_cpu;
  logic        irq;

  int checks = 0;
  int errors = 0;

  switch_input #(.WIDTH(32), .DEBOUNCE_CYCLES(20'd4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .we(we), .addr(addr),
    .data_in(data_in), .switch_raw(switch_raw),
    .data_return_cpu(data_return_cpu), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: stable takes a value once the synchronised input has shown it for D+1 samples
  logic [31:0] m_s1, m_s2, m_val, m_stable, m_changed, m_diff;
  int          m_run;
  bit          m_pending, m_ie, m_valid = 0, m_evt, m_wr;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '1; m_s2 = '1; m_val = '1; m_run = 1; m_stable = '1;
      m_changed = '0; m_pending = 0; m_ie = 0; m_valid = 1;
    end else begin
      m_wr = enable && we && (addr == 2'd1);
      if (m_s2 == m_val) begin
        if (m_run < D + 1) m_run++;
      end else begin
        m_val = m_s2;
        m_run = 1;
      end
      m_evt = 0;
      m_diff = '0;
      if (m_run >= D + 1) begin
        m_diff = m_val ^ m_stable;
        m_stable = m_val;
        m_evt = (m_diff != 0);
      end
      if (m_evt) begin
        m_pending = 1;
        m_changed = (m_wr && data_in[1]) ? m_diff : (m_changed | m_diff);
      end else if (m_wr && data_in[1]) begin
        m_pending = 0;
        m_changed = '0;
      end
      if (m_wr) m_ie = data_in[0];
      m_s2 = m_s1;
      m_s1 = switch_raw;
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return ~m_stable;
      2'd1:    return {30'b0, m_pending, m_ie};
      2'd2:    return m_changed;
      default: return 32'h0;
    endcase
  endfunction

  // Per-cycle compare, late in the cycle after all input changes
  always @(posedge clk) begin
    #8;
    if (m_valid) begin
      checks++;
      if (data_return_cpu !== model_rd(addr)) begin
        errors++;
        $display("FAIL model_rd addr=%0d: got %h expected %h at %0t", addr, data_return_cpu, model_rd(addr), $time);
      end
      checks++;
      if (irq !== (m_pending && m_ie)) begin
        errors++;
        $display("FAIL model_irq: got %b expected %b at %0t", irq, m_pending && m_ie, $time);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    addr = a;
    #1;
    checks++;
    if (data_return_cpu !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, data_return_cpu, exp);
    end
  endtask

  task automatic expect_irq(input logic exp, input string name);
    checks++;
    if (irq !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, irq, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    enable = 1'b1; we = 1'b1; addr = a; data_in = d;
    tick(1);
    enable = 1'b0; we = 1'b0;
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    expect_rd(2'd0, 32'h0, "reset_data");
    expect_rd(2'd1, 32'h0, "reset_ctrl");
    expect_rd(2'd2, 32'h0, "reset_changed");
    expect_rd(2'd3, 32'h0, "reset_off3");
    expect_irq(1'b0, "reset_irq");
    tick(10);

    // bit0 press: visible exactly 7 cycles after the drive
    switch_raw = 32'hFFFF_FFFE;
    tick(6);
    expect_rd(2'd0, 32'h0, "bit0_early");
    tick(1);
    expect_rd(2'd0, 32'h1, "bit0_data");
    expect_rd(2'd2, 32'h1, "bit0_changed");
    expect_rd(2'd1, 32'h2, "bit0_ctrl");
    expect_irq(1'b0, "bit0_irq_masked");

    // Writes to read-only offsets are ignored
    wr(2'd0, 32'h0);
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd3, 32'hFFFF_FFFF);
    expect_rd(2'd2, 32'h1, "ro_write_changed");
    expect_rd(2'd0, 32'h1, "ro_write_data");

    // bit5 press with ie set
    wr(2'd1, 32'h2);
    wr(2'd1, 32'h1);
    expect_irq(1'b0, "ie_set_irq");
    switch_raw = ~32'h21;
    tick(6);
    expect_irq(1'b0, "bit5_irq_early");
    tick(1);
    expect_irq(1'b1, "bit5_irq");
    expect_rd(2'd2, 32'h20, "bit5_changed");
    wr(2'd1, 32'h3);
    expect_irq(1'b0, "w1c_irq");
    expect_rd(2'd2, 32'h0, "w1c_changed");
    expect_rd(2'd1, 32'h1, "w1c_ctrl");

    // bit3 bouncing every 2 cycles, then held pressed
    for (int i = 0; i < 10; i++) begin
      switch_raw = (i % 2 == 0) ? ~32'h29 : ~32'h21;
      tick(2);
      expect_rd(2'd0, 32'h21, "bounce_data");
    end
    switch_raw = ~32'h29;
    tick(6);
    expect_rd(2'd0, 32'h21, "bit3_early");
    tick(1);
    expect_rd(2'd0, 32'h29, "bit3_data");
    expect_rd(2'd2, 32'h08, "bit3_changed");
    expect_irq(1'b1, "bit3_irq");

    // W1C lands on the same edge as the bit7 stable update
    switch_raw = ~32'hA9;
    tick(6);
    wr(2'd1, 32'h3);
    expect_rd(2'd1, 32'h3, "race_ctrl");
    expect_rd(2'd2, 32'h80, "race_changed");
    expect_rd(2'd0, 32'hA9, "race_data");
    expect_irq(1'b1, "race_irq");

    // Reset two cycles before a pending update, then a fresh full window
    switch_raw = ~32'h29;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    expect_rd(2'd0, 32'h0, "rst_mid_data");
    expect_rd(2'd1, 32'h0, "rst_mid_ctrl");
    expect_rd(2'd2, 32'h0, "rst_mid_changed");
    tick(6);
    expect_rd(2'd0, 32'h0, "rst_window_early");
    tick(1);
    expect_rd(2'd0, 32'h29, "rst_window_data");
    expect_rd(2'd2, 32'h29, "rst_window_changed");
    expect_rd(2'd1, 32'h2, "rst_window_ctrl");
    expect_irq(1'b0, "rst_window_irq");

    // Randomized traffic checked by the per-cycle model compare
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 3) == 0) switch_raw = $urandom;
        else switch_raw[$urandom_range(0, 31)] = ~switch_raw[$urandom_range(0, 31)];
      end
      if ($urandom_range(0, 5) == 0) begin
        enable = 1'b1;
        we = ($urandom_range(0, 1) == 1);
        addr = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'($urandom_range(0, 3));
      end else begin
        enable = 1'b0;
        we = 1'b0;
        addr = 2'($urandom_range(0, 3));
      end
      data_in = $urandom;
      reset = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    reset = 1'b0;
    enable = 1'b0;
    we = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
